speaker_driver: RTL

SPEAKER_DRIVER -- requirements
Module: speaker_driver

---
 rtl/speaker_driver.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/speaker_driver.sv
// ---------------------------------------------------------------------------
// speaker_driver
//
// Purpose:
//   Buffers signed 16-bit audio samples in a small circular FIFO and plays
//   them out as a single-bit PWM stream. Each PWM period is 2^PWM_BITS
//   cycles long. One sample is consumed per period, in the boundary cycle
//   where the counter equals its all-ones value. The popped sample is
//   attenuated by an arithmetic right shift of (7 - vol_in). It is then
//   reduced to an 8-bit offset-binary duty level, which takes effect from
//   counter value 0 of the next period.
//
// Optional feature:
//   NOISE_SHAPE_EN - when defined, the 8 bits discarded during reduction are
//   kept as a residue. The residue is added back, with saturation, into the
//   next popped sample. This is first-order error feedback. When the macro
//   is undefined, plain truncation is used and no residue register exists.
//
// Ports:
//   clk_in        in   system clock, single domain
//   rst_in        in   asynchronous active-high reset
//   ready_in      in   one-cycle strobe qualifying signal_in
//   signal_in     in   16-bit two's-complement audio sample
//   enable_in     in   0 = mute (level forced to midscale at the boundary)
//   vol_in        in   3-bit volume, attenuation shift = 7 - vol_in
//   pwm_out       out  registered PWM bit (1 = release pad, 0 = drive low)
//   level_out     out  offset-binary duty level currently being played
//   overflow_out  out  sticky: an incoming sample was dropped (FIFO full)
//   underrun_out  out  sticky: a period boundary found the FIFO empty
// ---------------------------------------------------------------------------
module speaker_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int PWM_BITS   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ready_in,
  input  logic [15:0] signal_in,
  input  logic        enable_in,
  input  logic [2:0]  vol_in,
  output logic        pwm_out,
  output logic [7:0]  level_out,
  output logic        overflow_out,
  output logic        underrun_out
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // The compare width covers both the counter and the 8-bit level, so that
  // the duty comparison never truncates either operand.
  localparam int CW = (PWM_BITS > 8) ? PWM_BITS : 8;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Storage and state
  // -------------------------------------------------------------------------
  logic [15:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic [PWM_BITS-1:0] r_cnt;
  logic [7:0]          r_level;
  logic                r_pwm;
  logic                r_overflow;
  logic                r_underrun;

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic        w_boundary;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [15:0] w_rd_data;

  assign w_boundary = (r_cnt == {PWM_BITS{1'b1}});
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_COUNT);

  // Pop and push both look at the count from before this cycle. A sample
  // written into an empty FIFO on a boundary cycle is therefore not popped
  // until the following boundary (no write-through). A push into a full FIFO
  // is accepted when the same cycle also pops, because that frees a slot.
  assign w_pop     = w_boundary && !w_empty;
  assign w_push    = ready_in && (!w_full || w_pop);
  assign w_drop    = ready_in && w_full && !w_pop;
  assign w_rd_data = r_mem[r_rd_ptr];

  // The sample memory carries no reset. Its contents are only reachable
  // through the pointers and count, and those are cleared by reset.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= signal_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Attenuation and reduction to an 8-bit level
  // -------------------------------------------------------------------------
  logic [2:0]         w_shift;
  logic signed [15:0] w_scaled;
  logic [7:0]         w_s8;
  logic [7:0]         w_level_next;

  assign w_shift  = 3'd7 - vol_in;
  assign w_scaled = $signed(w_rd_data) >>> w_shift;

`ifdef NOISE_SHAPE_EN
  logic [7:0]  r_residue;
  logic [16:0] w_sum_wide;
  logic [15:0] w_sum;
  logic        w_sat;

  // The residue is non-negative and the scaled value is at least -32768.
  // The sum therefore only ever overflows in the positive direction.
  assign w_sum_wide = {w_scaled[15], w_scaled} + {9'h000, r_residue};
  assign w_sat      = (w_sum_wide[16:15] == 2'b01);
  assign w_sum      = w_sat ? 16'h7FFF : w_sum_wide[15:0];
  assign w_s8       = w_sum[15:8];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_residue <= 8'h00;
    end else if (w_boundary) begin
      if (!enable_in) begin
        r_residue <= 8'h00;
      end else if (w_pop) begin
        r_residue <= w_sum[7:0];
      end
    end
  end
`else
  assign w_s8 = 8'(w_scaled >>> 8);
`endif

  // Convert from two's complement to offset binary: -128 -> 0x00, 0 -> 0x80.
  assign w_level_next = {~w_s8[7], w_s8[6:0]};

  // -------------------------------------------------------------------------
  // PWM counter, level register, output and sticky flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt      <= '0;
      r_level    <= 8'h80;
      r_pwm      <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
      // The compare uses the level in force during this cycle. In the
      // boundary cycle the counter is all-ones, so the first cycle of every
      // period is low, and each period is high for exactly level_out cycles.
      r_pwm <= (CW'(r_cnt) < CW'(r_level));
      // Mute is applied at every boundary, even when the FIFO is empty, so
      // the output goes to midscale within one period of enable_in dropping.
      if (w_boundary) begin
        if (!enable_in) begin
          r_level <= 8'h80;
        end else if (w_pop) begin
          r_level <= w_level_next;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_boundary && w_empty) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign pwm_out      = r_pwm;
  assign level_out    = r_level;
  assign overflow_out = r_overflow;
  assign underrun_out = r_underrun;

endmodule
